vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port 1Kx8 VRAM arbiter (video > clear engine > CPU).
//            VRAM_ARBITER_CLEAR_EN compiles in the ascending clear engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int unsigned VBLANK_GATE = 1,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vid_req,
  input  logic [9:0] vid_addr,
  output logic [7:0] vid_data,
  output logic       vid_valid,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  output logic       cpu_ready,
  input  logic       vblank,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WR_ACK, S_RD_WAIT, S_RD_DATA} cpu_state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_e;

  cpu_state_e state_q, state_d;
  tag_e       tag1_q, tag1_d, tag2_q;
  logic [9:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_wdata_q, ram_wdata_d;
  logic       ram_we_q, ram_we_d;
  logic [7:0] vid_data_q, vid_data_d;
  logic       vid_valid_q, vid_valid_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic       cpu_ack_q, cpu_ack_d;

  logic       clr_busy;
  logic       clr_issue;
  logic [9:0] clr_addr;
  logic [7:0] clr_data;
  logic       cpu_grant;

`ifdef VRAM_ARBITER_CLEAR_EN
  logic       clr_busy_q, clr_busy_d;
  logic       clr_wrap_q, clr_wrap_d;
  logic [9:0] clr_cnt_q, clr_cnt_d;

  // clr_wrap_q holds busy for one cycle after the final write has issued
  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_wrap_d = clr_wrap_q;
    clr_cnt_d  = clr_cnt_q;
    if (!clr_busy_q) begin
      if (clear_start) clr_busy_d = 1'b1;
    end else if (clr_wrap_q) begin
      clr_busy_d = 1'b0;
      clr_wrap_d = 1'b0;
    end else if (!vid_req) begin
      clr_cnt_d = clr_cnt_q + 10'd1;
      if (clr_cnt_q == 10'h3FF) clr_wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_busy_q <= 1'b0;
      clr_wrap_q <= 1'b0;
      clr_cnt_q  <= 10'd0;
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_wrap_q <= clr_wrap_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  assign clr_busy  = clr_busy_q;
  assign clr_issue = clr_busy_q & ~clr_wrap_q & ~vid_req;
  assign clr_addr  = clr_cnt_q;
  assign clr_data  = CLEAR_VALUE;
`else
  logic unused_clear;
  assign unused_clear = clear_start ^ (^CLEAR_VALUE);
  assign clr_busy  = 1'b0;
  assign clr_issue = 1'b0;
  assign clr_addr  = 10'd0;
  assign clr_data  = 8'h00;
`endif

  // cpu_ack_q blocks the ack cycle so a held request is not re-granted
  assign cpu_grant = (state_q == S_IDLE) & cpu_req & ~cpu_ack_q & ~vid_req & ~clr_busy &
                     (~cpu_we | (VBLANK_GATE == 0) | vblank);

  always_comb begin
    state_d     = state_q;
    tag1_d      = TAG_NONE;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;

    if (vid_req) begin
      ram_addr_d = vid_addr;
      tag1_d     = TAG_VID;
    end else if (clr_issue) begin
      ram_addr_d  = clr_addr;
      ram_wdata_d = clr_data;
      ram_we_d    = 1'b1;
    end else if (cpu_grant) begin
      ram_addr_d = cpu_addr;
      if (cpu_we) begin
        ram_wdata_d = cpu_wdata;
        ram_we_d    = 1'b1;
      end else begin
        tag1_d = TAG_CPU;
      end
    end

    case (state_q)
      S_IDLE:    if (cpu_grant) state_d = cpu_we ? S_WR_ACK : S_RD_WAIT;
      S_WR_ACK:  begin cpu_ack_d = 1'b1; state_d = S_IDLE; end
      S_RD_WAIT: state_d = S_RD_DATA;
      S_RD_DATA: begin cpu_ack_d = 1'b1; state_d = S_IDLE; end
      default:   state_d = S_IDLE;
    endcase

    if (tag2_q == TAG_VID) begin
      vid_data_d  = ram_rdata;
      vid_valid_d = 1'b1;
    end
    if (tag2_q == TAG_CPU) cpu_rdata_d = ram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      ram_addr_q  <= 10'd0;
      ram_wdata_q <= 8'h00;
      ram_we_q    <= 1'b0;
      vid_data_q  <= 8'h00;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign vid_data   = vid_data_q;
  assign vid_valid  = vid_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_ready  = ~(cpu_req & ~cpu_ack_q);
  assign clear_busy = clr_busy;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter with a 1Kx8 synchronous RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vid_req, cpu_req, cpu_we, vblank, clear_start;
  logic [9:0] vid_addr, cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] vid_data, cpu_rdata, ram_wdata, ram_rdata;
  logic       vid_valid, cpu_ack, cpu_ready, clear_busy, ram_we;
  logic [9:0] ram_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int we_cnt = 0;

  logic [7:0] mem     [0:1023];
  logic [7:0] exp_mem [0:1023];

  int vq_cyc[$];
  int vq_dat[$];
  int cq[$];

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_ready(cpu_ready),
    .vblank(vblank), .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (ram_we === 1'b1) we_cnt <= we_cnt + 1;

  // Scoreboard: video entries carry the exact strobe cycle; data -1 = don't care
  always @(negedge clk) begin
    int ec, ed;
    if (vid_valid === 1'b1) begin
      checks++;
      if (vq_cyc.size() == 0) begin
        errors++;
        $display("FAIL vid_unexpected got vid_data=%02h at cycle %0d, none expected", vid_data, cyc);
      end else begin
        ec = vq_cyc.pop_front();
        ed = vq_dat.pop_front();
        if (cyc != ec || (ed >= 0 && vid_data !== ed[7:0])) begin
          errors++;
          $display("FAIL vid_data got %02h at cycle %0d, expected %0d at cycle %0d", vid_data, cyc, ed, ec);
        end
      end
    end
    if (cpu_ack === 1'b1) begin
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL cpu_ack_unexpected got ack at cycle %0d, none expected", cyc);
      end else begin
        ed = cq.pop_front();
        if (ed >= 0 && cpu_rdata !== ed[7:0]) begin
          errors++;
          $display("FAIL cpu_rdata got %02h expected %02h", cpu_rdata, ed[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int ack_cyc);
    ack_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        ack_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic vid_issue(input logic [9:0] a, input int exp);
    vid_req  = 1'b1;
    vid_addr = a;
    vq_cyc.push_back(cyc + 3);
    vq_dat.push_back(exp);
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, output int lat);
    int k, ac;
    k = cyc;
    cq.push_back(-1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    wait_ack(200, ac);
    lat = (ac < 0) ? -1 : ac - k;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vid_req = 0; vid_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    vblank = 1'b1; clear_start = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vid_valid, cpu_ack, ram_we, clear_busy} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b expected 0000", {vid_valid, cpu_ack, ram_we, clear_busy});
    end
    checks++;
    if (ram_addr !== 10'd0 || ram_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_ram_bus got addr=%03h wdata=%02h expected 0/0", ram_addr, ram_wdata);
    end
    checks++;
    if (vid_data !== 8'h00 || cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_data got vid=%02h cpu=%02h expected 00/00", vid_data, cpu_rdata);
    end
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b expected 1", cpu_ready);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [9:0] a [0:9];
    logic [7:0] d [0:9];
    int lat, w0;
    a[0] = 10'h155; d[0] = 8'hA5;
    a[1] = 10'h010; d[1] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      a[i+2] = 10'(i);
      d[i+2] = 8'hC0 + 8'(i);
    end
    w0 = we_cnt;
    for (int i = 0; i < 10; i++) begin
      cpu_write(a[i], d[i], lat);
      checks++;
      if (lat != 2) begin
        errors++; $display("FAIL write_latency addr=%03h got %0d expected 2", a[i], lat);
      end
    end
    checks++;
    if (we_cnt - w0 != 10) begin
      errors++; $display("FAIL write_count got %0d expected 10", we_cnt - w0);
    end
  endtask

  task automatic test_video_read();
    vid_issue(10'h155, int'(exp_mem[10'h155]));
    tick();
    vid_req = 1'b0;
    repeat (6) tick();
    checks++;
    if (vq_cyc.size() != 0) begin
      errors++; $display("FAIL vid_read pending got %0d expected 0", vq_cyc.size());
    end
    checks++;
    if (vid_data !== 8'hA5) begin
      errors++; $display("FAIL vid_hold got %02h expected a5", vid_data);
    end
  endtask

  task automatic test_collision();
    int k0, ac;
    logic ready_bad;
    ready_bad = 1'b0;
    cq.push_back(int'(exp_mem[10'h010]));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    vid_issue(10'h155, int'(exp_mem[10'h155]));
    @(negedge clk); if (cpu_ready !== 1'b0) ready_bad = 1'b1;
    tick();
    vid_issue(10'h000, int'(exp_mem[0]));
    @(negedge clk); if (cpu_ready !== 1'b0) ready_bad = 1'b1;
    tick();
    vid_req = 1'b0;
    k0 = cyc;
    ac = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin ac = cyc; break; end
      if (cpu_ready !== 1'b0) ready_bad = 1'b1;
    end
    checks++;
    if (ac != k0 + 3) begin
      errors++; $display("FAIL collision_ack_cycle got %0d expected %0d", ac, k0 + 3);
    end
    checks++;
    if (ready_bad || cpu_ready !== 1'b1) begin
      errors++; $display("FAIL collision_ready got bad=%b ready_at_ack=%b expected 0/1", ready_bad, cpu_ready);
    end
    checks++;
    if (cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL collision_rdata got %02h expected 3c", cpu_rdata);
    end
    tick();
    cpu_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_gating();
    int k, ac, w0;
    logic bad;
    bad = 1'b0;
    vblank = 1'b0;
    cq.push_back(-1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h2FF; cpu_wdata = 8'h7E;
    w0 = we_cnt;
    repeat (20) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || cpu_ready !== 1'b0 || cpu_ack !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL gate_stall got activity during vblank=0 expected none");
    end
    tick();
    vblank = 1'b1;
    k = cyc;
    wait_ack(50, ac);
    checks++;
    if (ac != k + 2) begin
      errors++; $display("FAIL gate_ack_cycle got %0d expected %0d", ac, k + 2);
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    exp_mem[10'h2FF] = 8'h7E;
    checks++;
    if (we_cnt - w0 != 1) begin
      errors++; $display("FAIL gate_write_count got %0d expected 1", we_cnt - w0);
    end
    vid_issue(10'h2FF, 8'h7E);
    tick();
    vid_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_streaming();
    int k0, ac;
    cq.push_back(int'(exp_mem[10'h155]));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
    for (int i = 0; i < 8; i++) begin
      vid_issue(10'(i), int'(exp_mem[i]));
      tick();
    end
    vid_req = 1'b0;
    k0 = cyc;
    wait_ack(50, ac);
    checks++;
    if (ac != k0 + 3) begin
      errors++; $display("FAIL stream_cpu_ack got %0d expected %0d", ac, k0 + 3);
    end
    tick();
    cpu_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (vq_cyc.size() != 0) begin
      errors++; $display("FAIL stream_pending got %0d expected 0", vq_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int k, k2, ac;
    cq.push_back(int'(exp_mem[10'h010]));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    k = cyc;
    wait_ack(50, ac);
    checks++;
    if (ac != k + 3 || cpu_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got cycle=%0d ready=%b expected %0d/1", ac, cpu_ready, k + 3);
    end
    tick();
    cpu_addr = 10'h155;
    cq.push_back(int'(exp_mem[10'h155]));
    k2 = cyc;
    wait_ack(50, ac);
    checks++;
    if (ac != k2 + 3 || cpu_rdata !== 8'hA5) begin
      errors++; $display("FAIL b2b_second got cycle=%0d rdata=%02h expected %0d/a5", ac, cpu_rdata, k2 + 3);
    end
    tick();
    cpu_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int k2, ac;
    logic bad;
    bad = 1'b0;
    cq.push_back(int'(exp_mem[10'h010]));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({vid_valid, cpu_ack, ram_we, clear_busy} !== 4'b0 || ram_addr !== 10'd0 || ram_wdata !== 8'h00 ||
        vid_data !== 8'h00 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs got strobes=%b addr=%03h wdata=%02h vid=%02h cpu=%02h expected all 0",
               {vid_valid, cpu_ack, ram_we, clear_busy}, ram_addr, ram_wdata, vid_data, cpu_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL midreset_ack got cpu_ack=1 during reset expected 0");
    end
    tick();
    reset_n = 1'b1;
    k2 = cyc;
    wait_ack(50, ac);
    checks++;
    if (ac != k2 + 3 || cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL midreset_reissue got cycle=%0d rdata=%02h expected %0d/3c", ac, cpu_rdata, k2 + 3);
    end
    tick();
    cpu_req = 1'b0;
    repeat (2) tick();
  endtask

`ifdef VRAM_ARBITER_CLEAR_EN
  task automatic test_clear();
    int nclr, last_iter;
    logic seq_bad, cpu_early, cpu_done, got_after, busy_at_last, busy_after, busy_start;
    nclr = 0; last_iter = -1;
    seq_bad = 0; cpu_early = 0; cpu_done = 0; got_after = 0; busy_at_last = 0; busy_after = 1;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    @(negedge clk);
    busy_start = clear_busy;
    tick();
    for (int i = 0; i < 3000 && !(got_after && cpu_done); i++) begin
      vid_req  = ($urandom_range(0, 3) == 0);
      vid_addr = 10'($urandom_range(0, 1023));
      if (vid_req) begin
        vq_cyc.push_back(cyc + 3);
        vq_dat.push_back(-1);
      end
      if (i == 10) begin
        cq.push_back(-1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h123; cpu_wdata = 8'h99;
      end
      clear_start = (i == 30);
      @(negedge clk);
      if (ram_we === 1'b1) begin
        if (ram_addr === 10'h123 && ram_wdata === 8'h99) begin
          if (nclr < 1024) cpu_early = 1'b1;
        end else begin
          if (ram_addr !== nclr[9:0] || ram_wdata !== 8'h00) seq_bad = 1'b1;
          nclr++;
          if (nclr == 1024) begin
            last_iter = i;
            busy_at_last = clear_busy;
          end
        end
      end
      if (last_iter >= 0 && i == last_iter + 1) begin
        busy_after = clear_busy;
        got_after = 1'b1;
      end
      if (cpu_ack === 1'b1) cpu_done = 1'b1;
      tick();
      if (cpu_done) begin cpu_req = 1'b0; cpu_we = 1'b0; end
    end
    vid_req = 1'b0; clear_start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    checks++;
    if (busy_start !== 1'b1) begin
      errors++; $display("FAIL clear_busy_rise got %b expected 1", busy_start);
    end
    checks++;
    if (seq_bad || nclr != 1024) begin
      errors++; $display("FAIL clear_sequence got writes=%0d order_bad=%b expected 1024/0", nclr, seq_bad);
    end
    checks++;
    if (busy_at_last !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL clear_busy_fall got at_last=%b after=%b expected 1/0", busy_at_last, busy_after);
    end
    checks++;
    if (cpu_early || !cpu_done) begin
      errors++; $display("FAIL clear_cpu_defer got early=%b done=%b expected 0/1", cpu_early, cpu_done);
    end
    for (int i = 0; i < 1024; i++) exp_mem[i] = 8'h00;
    exp_mem[10'h123] = 8'h99;
    repeat (4) tick();
    vid_issue(10'h155, int'(exp_mem[10'h155]));
    tick();
    vid_issue(10'h123, int'(exp_mem[10'h123]));
    tick();
    vid_req = 1'b0;
    repeat (5) tick();
  endtask
`else
  task automatic test_clear();
    int lat;
    logic bad;
    bad = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (clear_busy !== 1'b0 || ram_we !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL clear_disabled got busy or write activity expected none");
    end
    tick();
    cpu_write(10'h123, 8'h99, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL clear_disabled_write got latency %0d expected 2", lat);
    end
    vid_issue(10'h123, 8'h99);
    tick();
    vid_req = 1'b0;
    repeat (5) tick();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_video_read();
    test_collision();
    test_gating();
    test_streaming();
    test_back_to_back();
    test_reset_mid();
    test_clear();
    repeat (5) tick();
    checks++;
    if (vq_cyc.size() != 0 || cq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got vid=%0d cpu=%0d pending expected 0/0", vq_cyc.size(), cq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
